counter: RTL and testbench



---
 rtl/counter.sv | 34 +++
 tb/tb_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Synchronous up/down binary counter with parallel load and count enable.
// Priority on every rising edge: reset, then load, then enabled count, then hold.
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_in,
    input  logic             enable,
    input  logic             up,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] r_count;

    // Modulo-2^WIDTH arithmetic: the increment and decrement wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_in;
        end else if (enable) begin
            if (up) begin
                r_count <= r_count + WIDTH'(1);
            end else begin
                r_count <= r_count - WIDTH'(1);
            end
        end
    end

    assign count_out = r_count;

endmodule

// File: tb/tb_counter.sv
// Bench for counter: directed vector table from the test plan, then random
// stimulus checked against an arithmetic reference model.
module tb_counter;

    localparam int WIDTH = 4;
    localparam int MODULUS = 2 ** WIDTH;

    // clock/reset block
    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_in;
    logic             enable;
    logic             up;
    logic [WIDTH-1:0] count_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    counter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_in   (load_in),
        .enable    (enable),
        .up        (up),
        .count_out (count_out)
    );

    typedef struct {
        logic             rst;
        logic             ld;
        logic [WIDTH-1:0] li;
        logic             en;
        logic             dir;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [WIDTH-1:0] exp_q[$];
    int n_checks;
    int n_fail;
    int model;

    // reference model: the priority rules written as plain integer arithmetic
    function automatic int ref_next(int cur, logic rst, logic ld, int li, logic en, logic dir);
        if (rst) return 0;
        if (ld) return li;
        if (en && dir) return (cur + 1) % MODULUS;
        if (en) return (cur + MODULUS - 1) % MODULUS;
        return cur;
    endfunction

    // driver task: apply one cycle of controls, let one edge sample them
    task automatic drive(input logic rst, input logic ld, input logic [WIDTH-1:0] li,
                         input logic en, input logic dir);
        @(negedge clk);
        reset   = rst;
        load    = ld;
        load_in = li;
        enable  = en;
        up      = dir;
        @(posedge clk);
        #1;
    endtask

    // scoreboard check: compare count_out against the head of the expected queue
    task automatic check(input string name);
        logic [WIDTH-1:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expected queue empty, count_out=%b", name, count_out);
            return;
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (count_out !== exp) begin
            n_fail++;
            $display("FAIL %s: count_out=%b expected=%b", name, count_out, exp);
        end
    endtask

    function automatic vec_t mk(logic rst, logic ld, logic [WIDTH-1:0] li,
                                logic en, logic dir, logic [WIDTH-1:0] exp);
        vec_t v;
        v.rst = rst; v.ld = ld; v.li = li; v.en = en; v.dir = dir; v.exp = exp;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        load     = 1'b0;
        load_in  = '0;
        enable   = 1'b0;
        up       = 1'b0;

        // directed vectors:      rst   ld    li       en    up    expected
        vecs.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'b0000)); // reset from unknown
        vecs.push_back(mk(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'b0000)); // reset beats load
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0001));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0010));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0011));
        vecs.push_back(mk(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 4'b1010)); // load
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b1011));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b1100));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'b1011)); // direction change
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'b1010));
        vecs.push_back(mk(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 4'b0011)); // load beats decrement
        vecs.push_back(mk(1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 4'b1111));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0000)); // wrap up
        vecs.push_back(mk(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'b1111)); // wrap down
        vecs.push_back(mk(1'b0, 1'b0, 4'h5, 1'b0, 1'b1, 4'b1111)); // hold, up toggling
        vecs.push_back(mk(1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 4'b1111));
        vecs.push_back(mk(1'b0, 1'b0, 4'h7, 1'b0, 1'b1, 4'b1111));
        vecs.push_back(mk(1'b0, 1'b0, 4'h8, 1'b0, 1'b0, 4'b1111));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b1, 1'b1, 4'h9, 1'b1, 1'b1, 4'b0000)); // mid-count reset

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].li, vecs[i].en, vecs[i].dir);
            exp_q.push_back(vecs[i].exp);
            check($sformatf("vec%0d", i));
        end

        // hand sequence: long run up across the wrap point, then back down
        model = 0;
        drive(1'b0, 1'b1, 4'hD, 1'b0, 1'b0);
        exp_q.push_back(4'hD);
        check("seq_load_d");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
            exp_q.push_back(WIDTH'((13 + i + 1) % MODULUS));
            check($sformatf("seq_up%0d", i));
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
            exp_q.push_back(WIDTH'((18 - i - 1) % MODULUS));
            check($sformatf("seq_dn%0d", i));
        end
        model = int'(count_out === 4'hD ? 13 : 13);

        // random phase against the reference model
        for (int i = 0; i < 400; i++) begin
            logic             r_rst;
            logic             r_ld;
            logic [WIDTH-1:0] r_li;
            logic             r_en;
            logic             r_dir;
            r_rst = ($urandom_range(0, 19) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_li  = WIDTH'($urandom_range(0, MODULUS - 1));
            r_en  = ($urandom_range(0, 3) != 0);
            r_dir = 1'($urandom_range(0, 1));
            model = ref_next(model, r_rst, r_ld, int'(r_li), r_en, r_dir);
            drive(r_rst, r_ld, r_li, r_en, r_dir);
            exp_q.push_back(WIDTH'(model));
            check($sformatf("rand%0d", i));
        end

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
